// File: rtl/shift_mix_stage.sv
// rtl/shift_mix_stage.sv - AES ShiftRows + MixColumns stage with registered valid/ready output
// Optional 1-entry skid buffer enabled by defining SHIFT_MIX_SKID_EN.
module shift_mix_stage #(
  parameter int BUS_WIDTH = 128,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [BUS_WIDTH-1:0] Data_Sub,
  input  logic                 In_Last,
  input  logic [TAG_WIDTH-1:0] In_Tag,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [BUS_WIDTH-1:0] Data_Mix,
  output logic                 Out_Last,
  output logic [TAG_WIDTH-1:0] Out_Tag
);

  if (BUS_WIDTH != 128) begin : g_bad_width
    $error("shift_mix_stage: BUS_WIDTH must be 128");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // a[k] is row k of the column after ShiftRows, picked straight from the input state.
  function automatic logic [BUS_WIDTH-1:0] shift_mix(input logic [BUS_WIDTH-1:0] s,
                                                     input logic last);
    logic [7:0] a [4];
    logic [BUS_WIDTH-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(k + 4*((c + k) % 4)) -: 8];
      if (last) begin
        for (int k = 0; k < 4; k++) r[127 - 8*(k + 4*c) -: 8] = a[k];
      end else begin
        r[127 - 32*c -: 8] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
        r[119 - 32*c -: 8] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
        r[111 - 32*c -: 8] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
        r[103 - 32*c -: 8] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
      end
    end
    return r;
  endfunction

  logic [BUS_WIDTH-1:0] mixed;
  logic                 accept;

  assign mixed  = shift_mix(Data_Sub, In_Last);
  assign accept = In_Valid && In_Ready;

`ifdef SHIFT_MIX_SKID_EN
  logic                 skid_valid;
  logic [BUS_WIDTH-1:0] skid_data;
  logic                 skid_last;
  logic [TAG_WIDTH-1:0] skid_tag;

  assign In_Ready = !skid_valid;

  // Skid only fills while the output is stalled, so it never holds a word with Out_Valid low.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Out_Valid  <= 1'b0;
      Data_Mix   <= '0;
      Out_Last   <= 1'b0;
      Out_Tag    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_tag   <= '0;
    end else if (!Out_Valid || Out_Ready) begin
      if (skid_valid) begin
        Out_Valid  <= 1'b1;
        Data_Mix   <= skid_data;
        Out_Last   <= skid_last;
        Out_Tag    <= skid_tag;
        skid_valid <= 1'b0;
      end else if (accept) begin
        Out_Valid <= 1'b1;
        Data_Mix  <= mixed;
        Out_Last  <= In_Last;
        Out_Tag   <= In_Tag;
      end else begin
        Out_Valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= mixed;
      skid_last  <= In_Last;
      skid_tag   <= In_Tag;
    end
  end
`else
  assign In_Ready = !Out_Valid || Out_Ready;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Out_Valid <= 1'b0;
      Data_Mix  <= '0;
      Out_Last  <= 1'b0;
      Out_Tag   <= '0;
    end else if (accept) begin
      Out_Valid <= 1'b1;
      Data_Mix  <= mixed;
      Out_Last  <= In_Last;
      Out_Tag   <= In_Tag;
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_shift_mix_stage.sv
// tb/tb_shift_mix_stage.sv - randomized and directed self-checking bench for shift_mix_stage
module tb_shift_mix_stage;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         In_Valid;
  logic         In_Ready;
  logic [127:0] Data_Sub;
  logic         In_Last;
  logic [3:0]   In_Tag;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [127:0] Data_Mix;
  logic         Out_Last;
  logic [3:0]   Out_Tag;

  shift_mix_stage #(.BUS_WIDTH(128), .TAG_WIDTH(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .Data_Sub(Data_Sub),
    .In_Last(In_Last), .In_Tag(In_Tag),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Data_Mix(Data_Mix),
    .Out_Last(Out_Last), .Out_Tag(Out_Tag)
  );

  always #5 Clk = ~Clk;

`ifdef SHIFT_MIX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: full GF(2^8) multiply and explicit 4x4 state matrix.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic last);
    logic [7:0] st [4][4];
    logic [7:0] sh [4][4];
    logic [7:0] coef [4];
    logic [7:0] v;
    logic [127:0] r;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int n = 0; n < 16; n++) st[n % 4][n / 4] = d[127 - 8*n -: 8];
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++) sh[rr][c] = st[rr][(c + rr) % 4];
    r = '0;
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++) begin
        if (last) v = sh[rr][c];
        else begin
          v = 8'h00;
          for (int k = 0; k < 4; k++) v ^= gmul(coef[(k - rr + 4) % 4], sh[k][c]);
        end
        r[127 - 8*(rr + 4*c) -: 8] = v;
      end
    return r;
  endfunction

  typedef struct packed {
    logic [127:0] d;
    logic         last;
    logic [3:0]   tag;
  } word_t;

  word_t q[$];
  bit           have_prev = 0;
  bit           prev_acc, prev_drn, prev_stall;
  logic [127:0] prev_data;
  logic         prev_last;
  logic [3:0]   prev_tag;

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge Clk) begin
    word_t e;
    int held;
    if (!Rst) begin
      q.delete();
      have_prev = 0;
    end else begin
      held = q.size();
      check("mon_out_valid", Out_Valid, held != 0);
      check("mon_occupancy", held <= CAP, 1);
`ifdef SHIFT_MIX_SKID_EN
      check("mon_in_ready", In_Ready, held < 2);
`else
      check("mon_in_ready", In_Ready, !Out_Valid || Out_Ready);
`endif
      if (have_prev && !prev_acc && !prev_drn) check("mon_idle_hold", Data_Mix, prev_data);
      if (have_prev && prev_stall) begin
        check("mon_stall_valid", Out_Valid, 1);
        check("mon_stall_data", Data_Mix, prev_data);
        check("mon_stall_tag", {Out_Last, Out_Tag}, {prev_last, prev_tag});
      end
      if (Out_Valid && Out_Ready) begin
        if (q.size() == 0) check("mon_spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          check("mon_data", Data_Mix, e.d);
          check("mon_last_tag", {Out_Last, Out_Tag}, {e.last, e.tag});
        end
      end
      if (In_Valid && In_Ready) q.push_back('{d: ref_round(Data_Sub, In_Last), last: In_Last, tag: In_Tag});
      have_prev  = 1;
      prev_acc   = In_Valid && In_Ready;
      prev_drn   = Out_Valid && Out_Ready;
      prev_stall = Out_Valid && !Out_Ready;
      prev_data  = Data_Mix;
      prev_last  = Out_Last;
      prev_tag   = Out_Tag;
    end
  end

  task automatic tick(output bit acc, output bit drn, output logic [3:0] otag);
    @(negedge Clk);
    acc  = In_Valid && In_Ready;
    drn  = Out_Valid && Out_Ready;
    otag = Out_Tag;
    @(posedge Clk);
    #1;
  endtask

  task automatic send_one(input string nm, input logic [127:0] d, input logic last,
                          input logic [3:0] tag, input logic [127:0] exp);
    bit a, dr;
    logic [3:0] ot;
    In_Valid = 1; Data_Sub = d; In_Last = last; In_Tag = tag; Out_Ready = 1;
    tick(a, dr, ot);
    In_Valid = 0;
    check({nm, "_accept"}, a, 1);
    check({nm, "_valid"}, Out_Valid, 1);
    check({nm, "_data"}, Data_Mix, exp);
    check({nm, "_last_tag"}, {Out_Last, Out_Tag}, {last, tag});
    tick(a, dr, ot);
    check({nm, "_drain"}, dr, 1);
  endtask

  initial begin
    bit a, dr;
    logic [3:0] ot;
    logic [3:0] tags[$];
    int k, cyc, drains, first, lastc;

    Rst = 0; In_Valid = 0; Data_Sub = '0; In_Last = 0; In_Tag = '0; Out_Ready = 0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1;
    check("reset_out_valid", Out_Valid, 0);
    check("reset_data", Data_Mix, '0);
    check("reset_last_tag", {Out_Last, Out_Tag}, 0);
    check("reset_in_ready", In_Ready, 1);

    send_one("fips_rnd1", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'h1,
             128'h046681e5e0cb199a48f8d37a2806264c);
    send_one("fips_last", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 4'ha,
             128'hd4bf5d30e0b452aeb84111f11e2798e5);
    // Diagonal input so that column 0 entering MixColumns is db135345.
    send_one("mixcol0", 128'hdb000000_00130000_00005300_00000045, 1'b0, 4'h3,
             128'h8e4da1bc_00000000_00000000_00000000);

    // Stall with tags 1,2,3 offered.
    Out_Ready = 0; k = 1; In_Valid = 1;
    for (int i = 0; i < 5; i++) begin
      In_Tag = 4'(k); Data_Sub = {$urandom, $urandom, $urandom, $urandom}; In_Last = 1'($urandom);
      tick(a, dr, ot);
      if (a) k++;
    end
    check("stall_accepts", k - 1, CAP);
    check("stall_in_ready", In_Ready, 0);
    Out_Ready = 1; cyc = 0;
    while (tags.size() < 3 && cyc < 20) begin
      In_Valid = (k <= 3); In_Tag = 4'(k);
      Data_Sub = {$urandom, $urandom, $urandom, $urandom};
      tick(a, dr, ot);
      if (a) k++;
      if (dr) tags.push_back(ot);
      cyc++;
    end
    In_Valid = 0;
    check("release_count", tags.size(), 3);
    for (int i = 0; i < tags.size(); i++) check("release_order", tags[i], i + 1);

    // Streaming throughput.
    Out_Ready = 1; k = 0; drains = 0; first = -1; lastc = 0; cyc = 0;
    while (drains < 16 && cyc < 60) begin
      In_Valid = (k < 16); In_Tag = 4'(k); In_Last = 1'($urandom);
      Data_Sub = {$urandom, $urandom, $urandom, $urandom};
      tick(a, dr, ot);
      if (a) k++;
      if (dr) begin
        check("stream_tag", ot, drains);
        if (first < 0) first = cyc;
        lastc = cyc;
        drains++;
      end
      cyc++;
    end
    In_Valid = 0;
    check("stream_count", drains, 16);
    check("stream_no_bubble", lastc - first, 15);

    // Reset with words buffered.
    Out_Ready = 0; In_Valid = 1;
    for (int i = 0; i < 2; i++) begin
      In_Tag = 4'(i + 5); Data_Sub = {$urandom, $urandom, $urandom, $urandom};
      tick(a, dr, ot);
    end
    In_Valid = 0;
    check("prereset_valid", Out_Valid, 1);
    Rst = 0;
    #1;
    check("midreset_valid", Out_Valid, 0);
    check("midreset_data", Data_Mix, '0);
    check("midreset_tag", Out_Tag, 0);
    @(posedge Clk);
    #1 Rst = 1;
    check("postreset_in_ready", In_Ready, 1);
    check("postreset_valid", Out_Valid, 0);

    // Random traffic with varying backpressure.
    for (int seg = 0; seg < 4; seg++) begin
      for (int i = 0; i < 100; i++) begin
        In_Valid  = ($urandom_range(0, 3) != 0);
        Out_Ready = ($urandom_range(0, 3) < seg + 1);
        Data_Sub  = {$urandom, $urandom, $urandom, $urandom};
        In_Last   = ($urandom_range(0, 3) == 0);
        In_Tag    = 4'($urandom);
        tick(a, dr, ot);
      end
    end
    In_Valid = 0; Out_Ready = 1;
    repeat (5) tick(a, dr, ot);
    check("final_drain_empty", q.size(), 0);
    check("final_out_valid", Out_Valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
